uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 33 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and transmitter.
//   c_LOW / c_HIGH           : serial line levels (idle is c_HIGH)
//   c_DEFAULT_CYCLES_PER_BIT : 115200 baud from a 25 MHz clock
//   s_*                      : one-hot receiver FSM state encodings
package uart_pkg;

    localparam logic c_LOW  = 1'b0;
    localparam logic c_HIGH = 1'b1;

    localparam int unsigned c_DEFAULT_CYCLES_PER_BIT = 217;

    typedef logic [4:0] rx_state_t;

    localparam rx_state_t s_IDLE    = 5'b00001;
    localparam rx_state_t s_START   = 5'b00010;
    localparam rx_state_t s_DATA    = 5'b00100;
    localparam rx_state_t s_STOP    = 5'b01000;
    localparam rx_state_t s_CLEANUP = 5'b10000;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver.
//   i_SERIAL_DATA   : asynchronous serial line, idle high, 8N1, LSB first
//   o_PARALLEL_DATA : last correctly received byte
//   o_RX_DV         : one-cycle pulse, new byte on o_PARALLEL_DATA
//   o_RX_ACTIVE     : high from start-bit detection to frame completion
//   o_FRAME_ERR     : one-cycle pulse, stop bit sampled low
// modport master : the receiver (reads the line, drives the results)
// modport slave  : the line driver / byte consumer
interface uart_rx_if;

    logic       i_SERIAL_DATA;
    logic [7:0] o_PARALLEL_DATA;
    logic       o_RX_DV;
    logic       o_RX_ACTIVE;
    logic       o_FRAME_ERR;

    modport master (
        input  i_SERIAL_DATA,
        output o_PARALLEL_DATA,
        output o_RX_DV,
        output o_RX_ACTIVE,
        output o_FRAME_ERR
    );

    modport slave (
        output i_SERIAL_DATA,
        input  o_PARALLEL_DATA,
        input  o_RX_DV,
        input  o_RX_ACTIVE,
        input  o_FRAME_ERR
    );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for an asynchronous input.
//   i_CLK   : destination clock
//   i_RESET : synchronous active-high reset, both flops load c_RESET_VALUE
//   i_D     : asynchronous input
//   o_Q     : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter logic c_RESET_VALUE = 1'b1
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_meta <= c_RESET_VALUE;
            r_sync <= c_RESET_VALUE;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   c_CYCLES_PER_BIT : i_CLK cycles per serial bit (4..65535)
//   i_CLK            : clock, all state on rising edge
//   i_RESET          : synchronous active-high reset
//   bus (master)     : serial line in, received byte / pulses out
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
    input  logic      i_CLK,
    input  logic      i_RESET,
    uart_rx_if.master bus
);

    localparam int unsigned c_CNT_W = $clog2(c_CYCLES_PER_BIT);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CYCLES_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'((c_CYCLES_PER_BIT - 1) / 2);

    logic               w_rx;
    rx_state_t          r_state;
    logic [c_CNT_W-1:0] r_clk_count;
    logic [2:0]         r_bit_index;
    logic [7:0]         r_shift;
    logic [7:0]         r_parallel_data;
    logic               r_rx_dv;
    logic               r_frame_err;
    logic               r_rx_active;
    logic [1:0]         r_flush;
    logic               r_armed;

    sync_2ff #(
        .c_RESET_VALUE (c_HIGH)
    ) u_sync (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .i_D     (bus.i_SERIAL_DATA),
        .o_Q     (w_rx)
    );

    // The synchronizer reports "high" for two cycles after reset whatever
    // the line does. r_flush marks when its output reflects the real line;
    // only then can a high level arm start detection, so a line that is
    // still low after a mid-frame reset is not mistaken for a start edge.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_flush <= '0;
            r_armed <= 1'b0;
        end else begin
            r_flush <= {r_flush[0], 1'b1};
            if (r_flush[1] && (w_rx == c_HIGH)) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state         <= s_IDLE;
            r_clk_count     <= '0;
            r_bit_index     <= '0;
            r_shift         <= '0;
            r_parallel_data <= '0;
            r_rx_dv         <= 1'b0;
            r_frame_err     <= 1'b0;
            r_rx_active     <= 1'b0;
        end else begin
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                s_IDLE: begin
                    r_clk_count <= '0;
                    r_bit_index <= '0;
                    if (r_armed && (w_rx == c_LOW)) begin
                        r_state     <= s_START;
                        r_rx_active <= 1'b1;
                    end
                end

                s_START: begin
                    if (r_clk_count == c_HALF_LAST) begin
                        r_clk_count <= '0;
                        if (w_rx == c_LOW) begin
                            r_state <= s_DATA;
                        end else begin
                            r_state     <= s_IDLE;
                            r_rx_active <= 1'b0;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end
                end

                s_DATA: begin
                    if (r_clk_count != c_BIT_LAST) begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end else begin
                        r_clk_count          <= '0;
                        r_shift[r_bit_index] <= w_rx;
                        if (r_bit_index == 3'd7) begin
                            r_bit_index <= '0;
                            r_state     <= s_STOP;
                        end else begin
                            r_bit_index <= r_bit_index + 1'b1;
                        end
                    end
                end

                s_STOP: begin
                    if (r_clk_count != c_BIT_LAST) begin
                        r_clk_count <= r_clk_count + 1'b1;
                    end else begin
                        r_clk_count <= '0;
                        if (w_rx == c_HIGH) begin
                            r_parallel_data <= r_shift;
                            r_rx_dv         <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= s_CLEANUP;
                    end
                end

                s_CLEANUP: begin
                    // A held-low line (break) parks here until it goes high.
                    r_clk_count <= '0;
                    if (w_rx == c_HIGH) begin
                        r_state     <= s_IDLE;
                        r_rx_active <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= s_IDLE;
                    r_clk_count <= '0;
                    r_bit_index <= '0;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_PARALLEL_DATA = r_parallel_data;
    assign bus.o_RX_DV         = r_rx_dv;
    assign bus.o_FRAME_ERR     = r_frame_err;
    assign bus.o_RX_ACTIVE     = r_rx_active;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx with 16 cycles/bit.
module tb_uart_rx;

    localparam int unsigned c_CPB = 16;

    logic i_CLK = 1'b0;
    logic i_RESET = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .c_CYCLES_PER_BIT (c_CPB)
    ) dut (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .bus     (bus)
    );

    always #5 i_CLK = ~i_CLK;

    // Event log filled by the monitor, read by the main sequence.
    logic [7:0] dv_log[$];
    int ferr_n      = 0;
    int both_n      = 0;
    int long_n      = 0;
    int streak      = 0;
    int last_streak = 0;
    logic prev_dv   = 1'b0;
    logic prev_ferr = 1'b0;

    always @(negedge i_CLK) begin
        if (!i_RESET) begin
            if (bus.o_RX_DV === 1'b1) dv_log.push_back(bus.o_PARALLEL_DATA);
            if (bus.o_FRAME_ERR === 1'b1) ferr_n++;
            if (bus.o_RX_DV === 1'b1 && bus.o_FRAME_ERR === 1'b1) both_n++;
            if ((bus.o_RX_DV === 1'b1 && prev_dv) || (bus.o_FRAME_ERR === 1'b1 && prev_ferr)) long_n++;
            if (bus.o_RX_ACTIVE === 1'b1) begin
                streak++;
            end else if (streak != 0) begin
                last_streak = streak;
                streak = 0;
            end
        end
        prev_dv   = (bus.o_RX_DV === 1'b1);
        prev_ferr = (bus.o_FRAME_ERR === 1'b1);
    end

    // Reference model: bytes expected on o_RX_DV, total frame errors, held byte.
    logic [7:0] exp_q[$];
    int         exp_ferr  = 0;
    logic [7:0] last_good = 8'h00;
    int         rd        = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic send_bit(input logic v);
        bus.i_SERIAL_DATA = v;
        cycles(c_CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        bus.i_SERIAL_DATA = 1'b1;
    endtask

    // Compare all new o_RX_DV bytes and the frame-error total against the model.
    task automatic check_events(input string tag);
        int n_new;
        n_new = dv_log.size() - rd;
        chk({tag, "_dv_count"}, n_new, exp_q.size());
        for (int i = 0; i < n_new && i < exp_q.size(); i++) begin
            chk({tag, "_dv_byte"}, dv_log[rd + i], exp_q[i]);
        end
        rd = dv_log.size();
        exp_q.delete();
        chk({tag, "_ferr_total"}, ferr_n, exp_ferr);
        chk({tag, "_data_hold"}, bus.o_PARALLEL_DATA, last_good);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       good;
        int         gap;

        bus.i_SERIAL_DATA = 1'b1;
        i_RESET = 1'b1;
        cycles(4);
        i_RESET = 1'b0;
        cycles(1);
        chk("rst_data",   bus.o_PARALLEL_DATA, 8'h00);
        chk("rst_dv",     bus.o_RX_DV, 1'b0);
        chk("rst_ferr",   bus.o_FRAME_ERR, 1'b0);
        chk("rst_active", bus.o_RX_ACTIVE, 1'b0);
        cycles(8);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        last_good = 8'hA5;
        cycles(8);
        check_events("a5");

        // 4-cycle low glitch on an idle line
        bus.i_SERIAL_DATA = 1'b0;
        cycles(4);
        bus.i_SERIAL_DATA = 1'b1;
        cycles(24);
        check_events("glitch");
        chk("glitch_active_now", bus.o_RX_ACTIVE, 1'b0);
        chk("glitch_active_le8", (last_streak >= 1 && last_streak <= 8), 1'b1);

        // 0x3C with a low stop bit
        send_frame(8'h3C, 1'b0);
        exp_ferr++;
        cycles(16);
        check_events("3c_bad_stop");

        // Back-to-back 0x00, 0xFF, 0x55
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        last_good = 8'h55;
        cycles(8);
        check_events("b2b");

        // Reset during bit 4 of 0x81; transmitter finishes the frame anyway
        b = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        bus.i_SERIAL_DATA = b[4];
        cycles(8);
        i_RESET = 1'b1;
        cycles(2);
        i_RESET = 1'b0;
        cycles(c_CPB - 10);
        for (int i = 5; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        last_good = 8'h00;
        cycles(16);
        check_events("rst_mid_81");
        chk("rst_mid_active", bus.o_RX_ACTIVE, 1'b0);

        send_frame(8'h42, 1'b1);
        exp_q.push_back(8'h42);
        last_good = 8'h42;
        cycles(8);
        check_events("after_rst_42");

        // Break: line low for 20 bit periods
        bus.i_SERIAL_DATA = 1'b0;
        cycles(20 * c_CPB);
        chk("break_active_held", bus.o_RX_ACTIVE, 1'b1);
        bus.i_SERIAL_DATA = 1'b1;
        exp_ferr++;
        cycles(16);
        check_events("break");
        chk("break_idle_after", bus.o_RX_ACTIVE, 1'b0);

        // Randomized frames
        for (int k = 0; k < 20; k++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good);
            if (good) begin
                exp_q.push_back(b);
                last_good = b;
                gap = $urandom_range(0, 2);
            end else begin
                exp_ferr++;
                gap = 1 + $urandom_range(0, 2);
            end
            cycles(gap * c_CPB);
            check_events("rnd");
        end

        cycles(16);
        chk("never_dv_and_ferr", both_n, 0);
        chk("single_cycle_pulses", long_n, 0);
        chk("final_idle", bus.o_RX_ACTIVE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
